// File: rtl/tt6581_pkg.sv
// -----------------------------------------------------------------------------
// tt6581_pkg
//   Shared definitions for the envelope generator: voice count, prescaler
//   width, ADSR phase encoding, control FSM encoding and the rate table.
// -----------------------------------------------------------------------------
package tt6581_pkg;

   localparam int NUM_VOICES = 3;
   localparam int CNT_W      = 13;   // holds 3 * 1569

   typedef enum logic [2:0] {
      ENV_IDLE = 3'd0,
      ATTACK   = 3'd1,
      DECAY    = 3'd2,
      SUSTAIN  = 3'd3,
      RELEASE  = 3'd4
   } adsr_e;

   typedef enum logic [1:0] {
      CTRL_IDLE   = 2'd0,
      CTRL_LOAD   = 2'd1,
      CTRL_UPDATE = 2'd2,
      CTRL_SCALE  = 2'd3
   } ctrl_e;

   // Envelope updates per level step, indexed by the 4-bit rate nibble.
   localparam logic [CNT_W-1:0] RATE_PERIOD [16] = '{
      13'd1,   13'd2,   13'd3,   13'd5,
      13'd7,   13'd11,  13'd13,  13'd16,
      13'd20,  13'd49,  13'd98,  13'd157,
      13'd196, 13'd588, 13'd980, 13'd1569
   };

   // Decay and release run three times slower than attack for the same index.
   function automatic logic [CNT_W-1:0] phase_period(input logic [3:0] idx,
                                                     input logic       slow);
      logic [CNT_W-1:0] p;
      p = RATE_PERIOD[idx];
      return slow ? ((p << 1) + p) : p;
   endfunction

endpackage

// File: rtl/env_scaler.sv
// -----------------------------------------------------------------------------
// env_scaler
//   Registered 10x8 unsigned multiply of a raw sample by an envelope level.
//   The result is the top ten bits of the 18-bit product (truncating >> 8).
// Ports
//   clk_i     clock
//   rst_ni    asynchronous active-low reset
//   en_i      load the product register this cycle
//   wave_i    raw unsigned 10-bit sample
//   level_i   8-bit envelope level
//   scaled_o  registered (wave_i * level_i) >> 8
// -----------------------------------------------------------------------------
module env_scaler (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       en_i,
   input  logic [9:0] wave_i,
   input  logic [7:0] level_i,
   output logic [9:0] scaled_o
);

   logic [17:0] product;

   assign product = 18'(wave_i) * 18'(level_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scaled_o <= '0;
      end else if (en_i) begin
         scaled_o <= 10'(product >> 8);
      end
   end

endmodule

// File: rtl/envelope_generator.sv
// -----------------------------------------------------------------------------
// envelope_generator
//   Per-voice ADSR envelope generator. Each accepted request steps the
//   addressed voice's envelope once, scales the raw sample by the new level
//   and answers with a one-cycle ready pulse.
//
//   Handshake: env_start_i is a one-cycle request, sampled only while the
//   control FSM is idle; all request fields are captured in that cycle.
//   env_ready_o pulses exactly four cycles after the accepted start cycle.
//   Requests arriving while busy are dropped, never queued.
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   env_start_i      request strobe
//   env_voice_i      voice index (indices >= NUM_VOICES are answered with 0)
//   env_gate_i       gate bit of the voice
//   env_attack_i     attack rate index
//   env_decay_i      decay rate index
//   env_sustain_i    sustain level nibble
//   env_release_i    release rate index
//   wave_i           raw unsigned voice sample
//   env_ready_o      completion pulse
//   env_wave_o       enveloped sample, held until the next completion
//   env_level_o      level of the last-processed voice, held
//   dbg_state_o      control FSM state
//   dbg_adsr_o       ADSR phase of the last-processed voice, held
// -----------------------------------------------------------------------------
module envelope_generator
   import tt6581_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       env_start_i,
   input  logic [1:0] env_voice_i,
   input  logic       env_gate_i,
   input  logic [3:0] env_attack_i,
   input  logic [3:0] env_decay_i,
   input  logic [3:0] env_sustain_i,
   input  logic [3:0] env_release_i,
   input  logic [9:0] wave_i,
   output logic       env_ready_o,
   output logic [9:0] env_wave_o,
   output logic [7:0] env_level_o,
   output ctrl_e      dbg_state_o,
   output adsr_e      dbg_adsr_o
);

   // ---------------- control FSM ----------------
   ctrl_e state_q, state_d;
   logic  capture_en, load_en, update_en, scale_en;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= CTRL_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CTRL_IDLE:   if (env_start_i) state_d = CTRL_LOAD;
         CTRL_LOAD:   state_d = CTRL_UPDATE;
         CTRL_UPDATE: state_d = CTRL_SCALE;
         CTRL_SCALE:  state_d = CTRL_IDLE;
         default:     state_d = CTRL_IDLE;
      endcase
   end

   always_comb begin
      capture_en = 1'b0;
      load_en    = 1'b0;
      update_en  = 1'b0;
      scale_en   = 1'b0;
      case (state_q)
         CTRL_IDLE:   capture_en = env_start_i;
         CTRL_LOAD:   load_en    = 1'b1;
         CTRL_UPDATE: update_en  = 1'b1;
         CTRL_SCALE:  scale_en   = 1'b1;
         default:     capture_en = 1'b0;
      endcase
   end

   assign dbg_state_o = state_q;

   // ---------------- request capture ----------------
   logic [1:0] voice_q;
   logic       voice_ok_q;
   logic       gate_q;
   logic [3:0] atk_q, dec_q, sus_q, rel_q;
   logic [9:0] wave_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         voice_q    <= '0;
         voice_ok_q <= 1'b0;
         gate_q     <= 1'b0;
         atk_q      <= '0;
         dec_q      <= '0;
         sus_q      <= '0;
         rel_q      <= '0;
         wave_q     <= '0;
      end else if (capture_en) begin
         voice_q    <= env_voice_i;
         voice_ok_q <= (int'(env_voice_i) < NUM_VOICES);
         gate_q     <= env_gate_i;
         atk_q      <= env_attack_i;
         dec_q      <= env_decay_i;
         sus_q      <= env_sustain_i;
         rel_q      <= env_release_i;
         wave_q     <= wave_i;
      end
   end

   // ---------------- per-voice state (flop arrays) ----------------
   logic [7:0]       level_q [NUM_VOICES];
   adsr_e            adsr_q  [NUM_VOICES];
   logic [CNT_W-1:0] cnt_q   [NUM_VOICES];
   logic             gprev_q [NUM_VOICES];

   // Read mux; an out-of-range index matches nothing and reads as zero.
   logic [7:0]       rd_level;
   adsr_e            rd_adsr;
   logic [CNT_W-1:0] rd_cnt;
   logic             rd_gprev;

   always_comb begin
      rd_level = '0;
      rd_adsr  = ENV_IDLE;
      rd_cnt   = '0;
      rd_gprev = 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (int'(voice_q) == v) begin
            rd_level = level_q[v];
            rd_adsr  = adsr_q[v];
            rd_cnt   = cnt_q[v];
            rd_gprev = gprev_q[v];
         end
      end
   end

   // Working copy of the selected voice, loaded in LOAD.
   logic [7:0]       cur_level_q;
   adsr_e            cur_adsr_q;
   logic [CNT_W-1:0] cur_cnt_q;
   logic             cur_gprev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cur_level_q <= '0;
         cur_adsr_q  <= ENV_IDLE;
         cur_cnt_q   <= '0;
         cur_gprev_q <= 1'b0;
      end else if (load_en) begin
         cur_level_q <= rd_level;
         cur_adsr_q  <= rd_adsr;
         cur_cnt_q   <= rd_cnt;
         cur_gprev_q <= rd_gprev;
      end
   end

   // ---------------- envelope step (combinational, used in UPDATE) ----------------
   logic [7:0]       s8, atk_lvl, dec_lvl, rel_lvl;
   logic [CNT_W-1:0] period;
   logic             counting, step_due;
   logic [7:0]       lvl_n;
   adsr_e            adsr_n;
   logic [CNT_W-1:0] cnt_n;
   logic [7:0]       level_new;
   adsr_e            adsr_new;

   assign s8      = {sus_q, sus_q};
   assign atk_lvl = (cur_level_q == 8'hFF) ? 8'hFF : cur_level_q + 8'd1;
   assign dec_lvl = (cur_level_q > s8)     ? cur_level_q - 8'd1 : cur_level_q;
   assign rel_lvl = (cur_level_q != 8'h00) ? cur_level_q - 8'd1 : 8'h00;

   always_comb begin
      period = '0;
      case (cur_adsr_q)
         ATTACK:  period = phase_period(atk_q, 1'b0);
         DECAY:   period = phase_period(dec_q, 1'b1);
         RELEASE: period = phase_period(rel_q, 1'b1);
         default: period = '0;
      endcase
   end

   // Sustain and idle have nothing to time, so their prescaler stays at 0.
   // '>=' rather than '==' lets a rate change to a shorter period step
   // immediately instead of wrapping the prescaler.
   assign counting = (cur_adsr_q == ATTACK) || (cur_adsr_q == DECAY) ||
                     (cur_adsr_q == RELEASE);
   assign step_due = counting && (cur_cnt_q >= (period - CNT_W'(1)));

   always_comb begin
      lvl_n  = cur_level_q;
      adsr_n = cur_adsr_q;
      cnt_n  = cur_cnt_q;
      if (gate_q && !cur_gprev_q) begin
         // Retrigger keeps the current level.
         adsr_n = ATTACK;
         cnt_n  = '0;
      end else if (!gate_q && cur_gprev_q) begin
         adsr_n = RELEASE;
         cnt_n  = '0;
      end else if (step_due) begin
         cnt_n = '0;
         case (cur_adsr_q)
            ATTACK: begin
               lvl_n = atk_lvl;
               if (atk_lvl == 8'hFF) adsr_n = DECAY;
            end
            DECAY: begin
               lvl_n = dec_lvl;
               if (dec_lvl <= s8) adsr_n = SUSTAIN;
            end
            RELEASE: begin
               lvl_n = rel_lvl;
               if (rel_lvl == 8'h00) adsr_n = ENV_IDLE;
            end
            default: lvl_n = cur_level_q;
         endcase
      end else if (counting) begin
         cnt_n = cur_cnt_q + CNT_W'(1);
      end
   end

   assign level_new = voice_ok_q ? lvl_n  : 8'h00;
   assign adsr_new  = voice_ok_q ? adsr_n : ENV_IDLE;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            level_q[v] <= '0;
            adsr_q[v]  <= ENV_IDLE;
            cnt_q[v]   <= '0;
            gprev_q[v] <= 1'b0;
         end
      end else if (update_en && voice_ok_q) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (int'(voice_q) == v) begin
               level_q[v] <= lvl_n;
               adsr_q[v]  <= adsr_n;
               cnt_q[v]   <= cnt_n;
               gprev_q[v] <= gate_q;
            end
         end
      end
   end

   // ---------------- scaling and outputs ----------------
   logic [7:0] level_new_q;
   adsr_e      adsr_new_q;
   logic [9:0] scaled;

   env_scaler u_scaler (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en_i     (update_en),
      .wave_i   (wave_q),
      .level_i  (level_new),
      .scaled_o (scaled)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         level_new_q <= '0;
         adsr_new_q  <= ENV_IDLE;
      end else if (update_en) begin
         level_new_q <= level_new;
         adsr_new_q  <= adsr_new;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         env_ready_o <= 1'b0;
         env_wave_o  <= '0;
         env_level_o <= '0;
         dbg_adsr_o  <= ENV_IDLE;
      end else begin
         env_ready_o <= scale_en;
         if (scale_en) begin
            env_wave_o  <= scaled;
            env_level_o <= level_new_q;
            dbg_adsr_o  <= adsr_new_q;
         end
      end
   end

endmodule

// File: tb/tb_envelope_generator.sv
`timescale 1ns/1ps
module tb_envelope_generator;
   import tt6581_pkg::*;

   // ---------------- clock / reset ----------------
   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       env_start_i = 1'b0;
   logic [1:0] env_voice_i = '0;
   logic       env_gate_i = 1'b0;
   logic [3:0] env_attack_i = '0, env_decay_i = '0, env_sustain_i = '0, env_release_i = '0;
   logic [9:0] wave_i = '0;
   logic       env_ready_o;
   logic [9:0] env_wave_o;
   logic [7:0] env_level_o;
   ctrl_e      dbg_state_o;
   adsr_e      dbg_adsr_o;

   always #10 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   envelope_generator dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .env_start_i   (env_start_i),
      .env_voice_i   (env_voice_i),
      .env_gate_i    (env_gate_i),
      .env_attack_i  (env_attack_i),
      .env_decay_i   (env_decay_i),
      .env_sustain_i (env_sustain_i),
      .env_release_i (env_release_i),
      .wave_i        (wave_i),
      .env_ready_o   (env_ready_o),
      .env_wave_o    (env_wave_o),
      .env_level_o   (env_level_o),
      .dbg_state_o   (dbg_state_o),
      .dbg_adsr_o    (dbg_adsr_o)
   );

   // ---------------- checking counters ----------------
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural envelope model ----------------
   // Each voice: level, phase, updates since last step, previous gate.
   int    per_tab [16] = '{1, 2, 3, 5, 7, 11, 13, 16, 20, 49, 98, 157, 196, 588, 980, 1569};
   int    m_level [3];
   adsr_e m_ph    [3];
   int    m_cnt   [3];
   bit    m_gprev [3];
   int    m_last_level;
   int    m_last_wave;
   adsr_e m_last_ph;

   task automatic model_reset();
      for (int v = 0; v < 3; v++) begin
         m_level[v] = 0;
         m_ph[v]    = ENV_IDLE;
         m_cnt[v]   = 0;
         m_gprev[v] = 0;
      end
   endtask

   task automatic model_apply(input int v, input int g, input int a, input int d,
                              input int s, input int r, input int w);
      int per, s8;
      if (v >= 3) begin
         m_last_level = 0;
         m_last_wave  = 0;
         m_last_ph    = ENV_IDLE;
         return;
      end
      s8 = s * 17;
      if (g == 1 && !m_gprev[v]) begin
         m_ph[v] = ATTACK; m_cnt[v] = 0;
      end else if (g == 0 && m_gprev[v]) begin
         m_ph[v] = RELEASE; m_cnt[v] = 0;
      end else if (m_ph[v] == ATTACK || m_ph[v] == DECAY || m_ph[v] == RELEASE) begin
         if (m_ph[v] == ATTACK)     per = per_tab[a];
         else if (m_ph[v] == DECAY) per = 3 * per_tab[d];
         else                       per = 3 * per_tab[r];
         if (m_cnt[v] + 1 >= per) begin
            m_cnt[v] = 0;
            if (m_ph[v] == ATTACK) begin
               if (m_level[v] < 255) m_level[v]++;
               if (m_level[v] == 255) m_ph[v] = DECAY;
            end else if (m_ph[v] == DECAY) begin
               if (m_level[v] > s8) m_level[v]--;
               if (m_level[v] <= s8) m_ph[v] = SUSTAIN;
            end else begin
               if (m_level[v] > 0) m_level[v]--;
               if (m_level[v] == 0) m_ph[v] = ENV_IDLE;
            end
         end else begin
            m_cnt[v]++;
         end
      end
      m_gprev[v]   = (g != 0);
      m_last_level = m_level[v];
      m_last_ph    = m_ph[v];
      m_last_wave  = (w * m_level[v]) / 256;
   endtask

   // ---------------- scoreboard ----------------
   // Entry: {phase[2:0], level[7:0], wave[9:0]}
   logic [20:0] exp_q[$];
   int          due_q[$];

   always @(negedge clk_i) begin
      logic        exp_rdy;
      logic [20:0] e;
      if (rst_ni) begin
         exp_rdy = (due_q.size() > 0) && (due_q[0] == cyc);
         chk("ready_timing", int'(env_ready_o), int'(exp_rdy));
         if (exp_rdy) begin
            void'(due_q.pop_front());
            e = exp_q.pop_front();
            if (env_ready_o) begin
               chk("sb_wave", int'(env_wave_o), int'(e[9:0]));
               chk("sb_level", int'(env_level_o), int'(e[17:10]));
               chk("sb_adsr", int'(dbg_adsr_o), int'(e[20:18]));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic scramble();
      env_voice_i   = 2'($urandom_range(0, 3));
      env_gate_i    = 1'($urandom_range(0, 1));
      env_attack_i  = 4'($urandom_range(0, 15));
      env_decay_i   = 4'($urandom_range(0, 15));
      env_sustain_i = 4'($urandom_range(0, 15));
      env_release_i = 4'($urandom_range(0, 15));
      wave_i        = 10'($urandom_range(0, 1023));
   endtask

   // One request every 10 cycles; 'poke' also raises start in the three busy
   // cycles with unrelated data, which must be ignored.
   task automatic xact(input int v, input int g, input int a, input int d,
                       input int s, input int r, input int w, input bit poke);
      @(posedge clk_i); #1;
      env_start_i   = 1'b1;
      env_voice_i   = 2'(v);
      env_gate_i    = 1'(g);
      env_attack_i  = 4'(a);
      env_decay_i   = 4'(d);
      env_sustain_i = 4'(s);
      env_release_i = 4'(r);
      wave_i        = 10'(w);
      model_apply(v, g, a, d, s, r, w);
      exp_q.push_back({m_last_ph, 8'(m_last_level), 10'(m_last_wave)});
      due_q.push_back(cyc + 4);
      for (int k = 1; k < 4; k++) begin
         @(posedge clk_i); #1;
         env_start_i = poke;
         scramble();
      end
      @(posedge clk_i); #1;
      env_start_i = 1'b0;
      scramble();
      repeat (5) @(posedge clk_i);
   endtask

   task automatic pin_level(input string name, input int exp);
      chk({name, "_dut"}, int'(env_level_o), exp);
      chk({name, "_model"}, m_last_level, exp);
   endtask

   task automatic pin_wave(input string name, input int exp);
      chk({name, "_dut"}, int'(env_wave_o), exp);
      chk({name, "_model"}, m_last_wave, exp);
   endtask

   task automatic pin_adsr(input string name, input adsr_e exp);
      chk({name, "_dut"}, int'(dbg_adsr_o), int'(exp));
      chk({name, "_model"}, int'(m_last_ph), int'(exp));
   endtask

   task automatic reset_mid_update();
      @(posedge clk_i); #1;
      env_start_i = 1'b1;
      env_voice_i = 2'd0;
      env_gate_i  = 1'b1;
      wave_i      = 10'h3FF;
      @(posedge clk_i); #1;
      env_start_i = 1'b0;
      @(posedge clk_i); #1;
      chk("mid_state_update", int'(dbg_state_o), int'(CTRL_UPDATE));
      rst_ni = 1'b0;
      model_reset();
      #2;
      chk("mid_rst_ready", int'(env_ready_o), 0);
      chk("mid_rst_wave", int'(env_wave_o), 0);
      chk("mid_rst_level", int'(env_level_o), 0);
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      repeat (6) @(posedge clk_i);
      chk("mid_rst_idle", int'(dbg_state_o), int'(CTRL_IDLE));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #3000000;
      $display("FAIL watchdog time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      model_reset();
      repeat (4) @(posedge clk_i);
      #1;
      chk("rst_ready", int'(env_ready_o), 0);
      chk("rst_wave", int'(env_wave_o), 0);
      chk("rst_level", int'(env_level_o), 0);
      rst_ni = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_state", int'(dbg_state_o), int'(CTRL_IDLE));

      // First request, gate low: level stays 0.
      xact(0, 0, 0, 0, 8, 0, 'h155, 0);
      pin_level("t1_level", 0);
      pin_wave("t1_wave", 0);

      // Attack at P=1: rising start, then one step per start.
      xact(0, 1, 0, 0, 8, 0, 'h3FF, 0);
      repeat (128) xact(0, 1, 0, 0, 8, 0, 'h3FF, 0);
      pin_level("t2_half", 'h80);
      pin_wave("t2_wave", 'h1FF);
      repeat (127) xact(0, 1, 0, 0, 8, 0, 'h3FF, 0);
      pin_level("t2_full", 'hFF);
      pin_adsr("t2_decay", DECAY);

      // Decay D=0 (3 updates/step) down to S8=0x88, then sustain holds.
      repeat (357) xact(0, 1, 0, 0, 8, 0, 'h3FF, 0);
      pin_level("t4_sus", 'h88);
      pin_adsr("t4_sus_ph", SUSTAIN);
      pin_wave("t4_wave", 'h21F);
      repeat (100) xact(0, 1, 0, 0, 3, 0, 'h3FF, 0);
      pin_level("t4_hold", 'h88);

      // Release R=0 from 0x88 to 0.
      xact(0, 0, 0, 0, 8, 0, 'h3FF, 0);
      repeat (408) xact(0, 0, 0, 0, 8, 0, 'h3FF, 0);
      pin_level("t5_rel", 0);
      pin_adsr("t5_idle", ENV_IDLE);

      // Attack A=1 on voice 2 with busy-window pokes.
      xact(2, 1, 1, 0, 8, 0, 'h200, 0);
      repeat (10) xact(2, 1, 1, 0, 8, 0, 'h200, 1);
      pin_level("t3_p2", 5);
      pin_wave("t3_wave", 10);

      // Rate change mid-attack: prescaler at 3, new period 1 steps at once.
      repeat (3) xact(2, 1, 3, 0, 8, 0, 'h200, 0);
      pin_level("rate_hold", 5);
      xact(2, 1, 0, 0, 8, 0, 'h200, 0);
      pin_level("rate_step", 6);
      repeat (74) xact(2, 1, 0, 0, 8, 0, 'h200, 0);
      pin_level("v2_peak", 'h50);

      // Release to 0x40, then retrigger keeps the level.
      xact(2, 0, 0, 0, 8, 0, 'h200, 0);
      repeat (48) xact(2, 0, 0, 0, 8, 0, 'h200, 0);
      pin_level("v2_rel40", 'h40);
      pin_adsr("v2_rel_ph", RELEASE);
      xact(2, 1, 0, 0, 8, 0, 'h200, 0);
      pin_level("v2_retrig", 'h40);
      pin_adsr("v2_retrig_ph", ATTACK);
      xact(2, 1, 0, 0, 8, 0, 'h200, 0);
      pin_level("v2_resume", 'h41);

      // Interleave v0 (gate high) and v1 (gate low).
      for (int i = 0; i < 10; i++) begin
         xact(0, 1, 0, 0, 8, 0, int'($urandom_range(0, 1023)), 0);
         xact(1, 0, 0, 0, 8, 0, int'($urandom_range(0, 1023)), 0);
      end
      pin_level("t6_v1", 0);
      xact(3, 1, 0, 0, 8, 0, 'h3FF, 0);
      pin_level("t6_bad_level", 0);
      pin_wave("t6_bad_wave", 0);
      xact(0, 1, 0, 0, 8, 0, 'h3FF, 0);
      pin_level("t6_v0", 10);

      // Reset during UPDATE: no ready, every voice cleared.
      reset_mid_update();
      xact(0, 0, 0, 0, 8, 0, 'h3FF, 0);
      pin_level("post_rst_v0", 0);
      xact(2, 0, 0, 0, 8, 0, 'h3FF, 0);
      pin_level("post_rst_v2", 0);
      pin_adsr("post_rst_v2_ph", ENV_IDLE);

      repeat (4) @(posedge clk_i);
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
